// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the multiplexed 8-digit display scanner.
//   scan_state_t : scan FSM states (IDLE, BLANK, SHOW)
//   NUM_DIGITS   : number of multiplexed digits
//   AN_OFF       : anode pattern with every digit dark (anodes are active-low)
//   LAST_DIGIT   : digit index scanned first in every frame
//   digit_anodes : active-low one-cold anode pattern for a digit index
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  AN_OFF     = 8'hFF;
  localparam logic [2:0]  LAST_DIGIT = 3'd7;

  function automatic logic [7:0] digit_anodes(input logic [2:0] idx);
    logic [7:0] pattern;
    pattern = AN_OFF;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        pattern[i] = 1'b0;
      end
    end
    return pattern;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Two-flop synchronizer followed by a stable-count debouncer. A new level on
// din is accepted onto dout only after the synchronized value has differed
// from dout for DEBOUNCE_CYCLES consecutive clock cycles; any return to the
// accepted level restarts the count.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset (all flops to 0)
//   din   : asynchronous raw switch input
//   dout  : debounced level
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_cnt_n;
  logic             dout_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
    end
  end

  // The count tracks how many consecutive cycles the synchronized level has
  // disagreed with dout; reaching the limit accepts it and clears the count.
  always_comb begin
    stable_cnt_n = '0;
    dout_n       = dout;
    if (sync_2 != dout) begin
      if (stable_cnt == CNT_LAST) begin
        dout_n = sync_2;
      end else begin
        stable_cnt_n = stable_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else begin
      stable_cnt <= stable_cnt_n;
      dout       <= dout_n;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Each digit gets a slot of TICK_DIV cycles: BLANK_CYCLES with every anode off
// (ghosting guard), then the remainder with that digit's anode on. Digits are
// scanned 7 down to 0; frame_tick pulses once per completed frame. The name
// select switch is debounced and only handed to the segment decoder at a frame
// boundary (or while idle), so a frame never mixes two names.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   enable     : 1 = scan, 0 = blank and return to idle
//   sw_raw     : asynchronous name-select switch
//   CountAN    : current digit index for the segment decoder
//   AN         : anodes, active-low, bit i = digit i
//   sw_sel     : debounced, frame-aligned name select
//   frame_tick : one-cycle pulse after the last slot of a frame
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES    = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       sw_raw,
  output logic [2:0] CountAN,
  output logic [7:0] AN,
  output logic       sw_sel,
  output logic       frame_tick
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned SLOT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Terminal counts of the slot counter for each phase of a slot.
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SHOW_LAST  = SLOT_W'(TICK_DIV - BLANK_CYCLES - 1);

  scan_state_t       state;
  scan_state_t       state_n;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_cnt_n;
  logic [2:0]        digit_n;
  logic [7:0]        an_n;
  logic              tick_n;
  logic              sel_n;
  logic              pending;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (clock),
    .reset (reset),
    .din   (sw_raw),
    .dout  (pending)
  );

  // All outputs are registered: the comb block computes their values for the
  // state being entered, so AN/CountAN change exactly on phase boundaries.
  always_comb begin
    state_n    = state;
    slot_cnt_n = slot_cnt;
    digit_n    = CountAN;
    an_n       = AN;
    tick_n     = 1'b0;
    sel_n      = sw_sel;

    // Frame alignment of the name select: hand over the debounced level in
    // the frame_tick cycle, or at any time while the display is idle.
    if ((state == IDLE) || frame_tick) begin
      sel_n = pending;
    end

    if (!enable) begin
      state_n    = IDLE;
      slot_cnt_n = '0;
      digit_n    = LAST_DIGIT;
      an_n       = AN_OFF;
    end else begin
      case (state)
        IDLE: begin
          state_n    = BLANK;
          slot_cnt_n = '0;
          digit_n    = LAST_DIGIT;
          an_n       = AN_OFF;
        end
        BLANK: begin
          if (slot_cnt == BLANK_LAST) begin
            state_n    = SHOW;
            slot_cnt_n = '0;
            an_n       = digit_anodes(CountAN);
          end else begin
            slot_cnt_n = slot_cnt + SLOT_W'(1);
          end
        end
        SHOW: begin
          if (slot_cnt == SHOW_LAST) begin
            state_n    = BLANK;
            slot_cnt_n = '0;
            an_n       = AN_OFF;
            // 3-bit decrement wraps 0 -> 7, starting the next frame.
            digit_n    = CountAN - 3'd1;
            tick_n     = (CountAN == 3'd0);
          end else begin
            slot_cnt_n = slot_cnt + SLOT_W'(1);
          end
        end
        default: begin
          state_n    = IDLE;
          slot_cnt_n = '0;
          digit_n    = LAST_DIGIT;
          an_n       = AN_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      CountAN    <= LAST_DIGIT;
      AN         <= AN_OFF;
      frame_tick <= 1'b0;
      sw_sel     <= 1'b0;
    end else begin
      state      <= state_n;
      slot_cnt   <= slot_cnt_n;
      CountAN    <= digit_n;
      AN         <= an_n;
      frame_tick <= tick_n;
      sw_sel     <= sel_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl with TICK_DIV=10, BLANK_CYCLES=2,
// DEBOUNCE_CYCLES=4. The reference model describes the display in terms of
// elapsed cycles since scanning started: slot = t / TICK_DIV, position within
// the slot = t % TICK_DIV, digit = 7 - slot % 8. The switch model accepts a
// level once the last four synchronized samples all agree on a new value.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int unsigned TICK  = 10;
  localparam int unsigned BLNK  = 2;
  localparam int unsigned DEB   = 4;
  localparam int unsigned FRAME = 8 * TICK;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       sw_raw;
  logic [2:0] CountAN;
  logic [7:0] AN;
  logic       sw_sel;
  logic       frame_tick;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  int unsigned k;          // clock edges since scanning started (0 = idle)
  logic        m_s1, m_s2, m_pend, m_sel;
  logic        sync_hist[$];

  always #5 clock = ~clock;

  display_scan_ctrl #(
    .CLK_FREQ_HZ     (1000),
    .REFRESH_HZ      (100),
    .BLANK_CYCLES    (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sw_raw     (sw_raw),
    .CountAN    (CountAN),
    .AN         (AN),
    .sw_sel     (sw_sel),
    .frame_tick (frame_tick)
  );

  function automatic logic [7:0] exp_an(input int unsigned kk);
    int unsigned t;
    int unsigned digit;
    logic [7:0]  one;
    if (kk == 0) return 8'hFF;
    t = kk - 1;
    if ((t % TICK) < BLNK) return 8'hFF;
    digit = 7 - ((t / TICK) % 8);
    one = 8'd1 << digit;
    return ~one;
  endfunction

  function automatic logic [7:0] exp_digit(input int unsigned kk);
    if (kk == 0) return 8'd7;
    return 8'(7 - (((kk - 1) / TICK) % 8));
  endfunction

  function automatic logic exp_tick(input int unsigned kk);
    return (kk > 1) && (((kk - 1) % FRAME) == 0);
  endfunction

  task automatic model_reset();
    k      = 0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_pend = 1'b0;
    m_sel  = 1'b0;
    sync_hist.delete();
  endtask

  task automatic model_edge();
    logic sel_nx;
    logic agree;
    sel_nx = ((k == 0) || exp_tick(k)) ? m_pend : m_sel;
    sync_hist.push_back(m_s2);
    if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
    if (sync_hist.size() == DEB) begin
      agree = 1'b1;
      foreach (sync_hist[i]) if (sync_hist[i] != m_s2) agree = 1'b0;
      if (agree && (m_s2 != m_pend)) m_pend = m_s2;
    end
    m_s2  = m_s1;
    m_s1  = sw_raw;
    k     = enable ? k + 1 : 0;
    m_sel = sel_nx;
  endtask

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
  endtask

  task automatic check_all();
    check1("AN", AN, exp_an(k));
    check1("CountAN", {5'd0, CountAN}, exp_digit(k));
    check1("frame_tick", {7'd0, frame_tick}, {7'd0, exp_tick(k)});
    check1("sw_sel", {7'd0, sw_sel}, {7'd0, m_sel});
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int unsigned run_len;

    // Reset state
    reset  = 1'b1;
    enable = 1'b1;
    sw_raw = 1'b0;
    model_reset();
    #12;
    check1("rst_AN", AN, 8'hFF);
    check1("rst_CountAN", {5'd0, CountAN}, 8'd7);
    check1("rst_sw_sel", {7'd0, sw_sel}, 8'd0);
    check1("rst_frame_tick", {7'd0, frame_tick}, 8'd0);
    @(negedge clock);
    reset = 1'b0;

    // First frames: slot timing, frame tick, sw_raw rising at cycle 15
    for (int unsigned n = 1; n <= 200; n++) begin
      if (n == 15) sw_raw = 1'b1;
      step();
      if (n == 2)  check1("first_blank_AN", AN, 8'hFF);
      if (n == 3)  check1("first_show_AN", AN, 8'h7F);
      if (n == 10) check1("digit7_last_AN", AN, 8'h7F);
      if (n == 12) check1("second_blank_AN", AN, 8'hFF);
      if (n == 13) begin
        check1("digit6_AN", AN, 8'hBF);
        check1("digit6_CountAN", {5'd0, CountAN}, 8'd6);
      end
      if (n == 80) check1("sel_before_frame", {7'd0, sw_sel}, 8'd0);
      if (n == 81) begin
        check1("frame_tick_80", {7'd0, frame_tick}, 8'd1);
        check1("frame_wrap_CountAN", {5'd0, CountAN}, 8'd7);
      end
      if (n == 82) check1("sel_after_frame", {7'd0, sw_sel}, 8'd1);
    end

    // 3-cycle glitch away from the accepted level must be ignored
    sw_raw = 1'b0;
    step(); step(); step();
    sw_raw = 1'b1;
    for (int unsigned n = 0; n < 100; n++) step();
    check1("glitch_sel_held", {7'd0, sw_sel}, 8'd1);

    // Drop enable during SHOW of digit 4
    for (int unsigned n = 0; n < 100; n++) begin
      if ((exp_digit(k) == 8'd4) && (exp_an(k) != 8'hFF)) break;
      step();
    end
    check1("reach_digit4_show", AN, 8'hEF);
    enable = 1'b0;
    step();
    check1("disable_AN", AN, 8'hFF);
    check1("disable_CountAN", {5'd0, CountAN}, 8'd7);
    enable = 1'b1;
    step();
    step();
    check1("reenable_blank_AN", AN, 8'hFF);
    step();
    check1("reenable_show_AN", AN, 8'h7F);

    // Randomized switch activity and occasional enable drops
    run_len = 0;
    for (int unsigned n = 0; n < 2000; n++) begin
      if (run_len == 0) begin
        sw_raw  = 1'($urandom_range(0, 1));
        run_len = $urandom_range(1, 8);
      end
      run_len--;
      enable = ($urandom_range(0, 99) >= 2);
      step();
    end

    // Asynchronous reset mid-SHOW with sw_sel previously 1
    enable = 1'b1;
    sw_raw = 1'b1;
    for (int unsigned n = 0; n < 200; n++) step();
    for (int unsigned n = 0; n < 20; n++) begin
      if ((exp_an(k) != 8'hFF) && ((k - 1) % TICK) < (TICK - 2)) break;
      step();
    end
    check1("pre_reset_sel", {7'd0, sw_sel}, 8'd1);
    check1("pre_reset_show", {7'd0, (AN != 8'hFF)}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check1("async_rst_AN", AN, 8'hFF);
    check1("async_rst_CountAN", {5'd0, CountAN}, 8'd7);
    check1("async_rst_sw_sel", {7'd0, sw_sel}, 8'd0);
    check1("async_rst_frame_tick", {7'd0, frame_tick}, 8'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int unsigned n = 0; n < 100; n++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
